seg7_scan_decoder: RTL and testbench

//  Receive side of the multiplexed 7-seg display path. Samples a one-cold anode

---
 rtl/seg7_scan_decoder.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-seg receive path: filters stable scans, decodes each digit, hands out whole frames.
// Latency: frame_valid rises 2 cycles after the last capturing sample; backpressure holds the frame, later scans dropped.
// SEG7_HEX_EN: when defined, also decodes hex glyphs A..F.
module seg7_scan_decoder #(
    parameter int NDIG   = 8,
    parameter int STABLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [NDIG-1:0]     an,
    input  logic [6:0]          seg,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [4*NDIG-1:0]   frame_digits,
    output logic [NDIG-1:0]     frame_blank,
    output logic [NDIG-1:0]     frame_err
);

    typedef enum logic {COLLECT, PEND} state_t;

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    state_t              state, state_next;
    logic [3:0]          count, count_next;
    logic [NDIG-1:0]     prev_an;
    logic [6:0]          prev_seg;
    logic [NDIG-1:0]     mask;
    logic [4*NDIG-1:0]   sh_digits;
    logic [NDIG-1:0]     sh_blank, sh_err;

    logic [3:0]          dec_val;
    logic                dec_blank, dec_err;
    logic [NDIG-1:0]     an_low;
    logic                one_cold, same_run;
    logic                capture, load, take_sample;

    assign an_low   = ~an;
    assign one_cold = (an_low != '0) && ((an_low & (an_low - NDIG'(1))) == '0);
    assign same_run = (an == prev_an) && (seg == prev_seg);

    always_comb begin
        dec_val   = 4'hF;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg)
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
            7'b1111111: begin
                dec_val   = 4'h0;
                dec_blank = 1'b1;
            end
`ifdef SEG7_HEX_EN
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
`endif
            default:    dec_err = 1'b1;
        endcase
    end

    // Capture fires only on the sample where the run length first hits STABLE.
    always_comb begin
        state_next  = state;
        count_next  = count;
        capture     = 1'b0;
        load        = 1'b0;
        take_sample = 1'b0;
        case (state)
            COLLECT: begin
                if (sample_en) begin
                    if (!one_cold) begin
                        count_next = 4'd0;
                    end else if (same_run) begin
                        take_sample = 1'b1;
                        count_next  = (count == 4'd15) ? count : count + 4'd1;
                        capture     = (count != 4'd15) && ((count + 4'd1) == STABLE_C);
                    end else begin
                        take_sample = 1'b1;
                        count_next  = 4'd1;
                        capture     = (STABLE_C == 4'd1);
                    end
                end
                if (&mask) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                count_next = 4'd0;
                if (!frame_valid || frame_ready) begin
                    load       = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
                count_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= COLLECT;
            count    <= 4'd0;
            prev_an  <= '1;
            prev_seg <= '1;
            mask     <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (take_sample) begin
                prev_an  <= an;
                prev_seg <= seg;
            end
            if (load) begin
                mask <= '0;
            end else if (capture) begin
                mask <= mask | an_low;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_digits <= '0;
            sh_blank  <= '0;
            sh_err    <= '0;
        end else if (capture) begin
            for (int k = 0; k < NDIG; k++) begin
                if (!an[k]) begin
                    sh_digits[4*k +: 4] <= dec_val;
                    sh_blank[k]         <= dec_blank;
                    sh_err[k]           <= dec_err;
                end
            end
        end
    end

    // A load coinciding with an accept keeps frame_valid high for the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid  <= 1'b0;
            frame_digits <= '0;
            frame_blank  <= '0;
            frame_err    <= '0;
        end else if (load) begin
            frame_valid  <= 1'b1;
            frame_digits <= sh_digits;
            frame_blank  <= sh_blank;
            frame_err    <= sh_err;
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: spec-level model pushes expected frames, a monitor checks handouts.
module tb_seg7_scan_decoder;

    localparam int NDIG   = 8;
    localparam int STABLE = 2;

    localparam logic [6:0] SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                            7'b0000000, 7'b0000100};
    localparam logic [6:0] HEX_TAB [6]  = '{7'b0001000, 7'b1100000, 7'b0110001,
                                            7'b1000010, 7'b0110000, 7'b0111000};

    typedef struct packed {
        logic [4*NDIG-1:0] dig;
        logic [NDIG-1:0]   blank;
        logic [NDIG-1:0]   err;
    } frame_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sample_en = 1'b0;
    logic [NDIG-1:0]     an = '1;
    logic [6:0]          seg = '1;
    logic                frame_valid;
    logic                frame_ready = 1'b1;
    logic [4*NDIG-1:0]   frame_digits;
    logic [NDIG-1:0]     frame_blank;
    logic [NDIG-1:0]     frame_err;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .an           (an),
        .seg          (seg),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_digits (frame_digits),
        .frame_blank  (frame_blank),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int frames_pushed = 0;
    int frames_flushed = 0;
    int frames_rcv = 0;
    frame_t exp_q[$];

    // Reference model state: per-digit captured values and the current run length.
    logic [3:0]      m_val [NDIG];
    bit              m_blank [NDIG];
    bit              m_err [NDIG];
    bit              m_have [NDIG];
    int              m_run = 0;
    logic [NDIG-1:0] m_prev_an = '1;
    logic [6:0]      m_prev_seg = '1;
    bit              m_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic void decode_ref(input logic [6:0] s, output logic [3:0] v,
                                       output bit b, output bit e);
        v = 4'hF; b = 0; e = 1;
        if (s == 7'h7F) begin
            v = 4'h0; b = 1; e = 0;
        end
        for (int i = 0; i < 10; i++)
            if (SEG_TAB[i] == s) begin v = 4'(i); e = 0; end
`ifdef SEG7_HEX_EN
        for (int i = 0; i < 6; i++)
            if (HEX_TAB[i] == s) begin v = 4'(10 + i); e = 0; end
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) m_have[i] = 0;
        m_run = 0;
        frames_flushed += exp_q.size();
        exp_q.delete();
    endtask

    task automatic model_sample(input logic [NDIG-1:0] a, input logic [6:0] s);
        int zeros = 0, pos = 0, prior, nrun;
        bit all;
        frame_t f;
        for (int i = 0; i < NDIG; i++)
            if (!a[i]) begin zeros++; pos = i; end
        if (zeros != 1) begin
            m_run = 0;
            return;
        end
        prior = (a == m_prev_an && s == m_prev_seg) ? m_run : 0;
        nrun  = (prior + 1 > 15) ? 15 : prior + 1;
        m_prev_an = a; m_prev_seg = s; m_run = nrun;
        if (prior < STABLE && nrun >= STABLE) begin
            decode_ref(s, m_val[pos], m_blank[pos], m_err[pos]);
            m_have[pos] = 1;
            all = 1;
            for (int i = 0; i < NDIG; i++) all = all & m_have[i];
            if (all) begin
                for (int i = 0; i < NDIG; i++) begin
                    f.dig[4*i +: 4] = m_val[i];
                    f.blank[i]      = m_blank[i];
                    f.err[i]        = m_err[i];
                    m_have[i]       = 0;
                end
                exp_q.push_back(f);
                frames_pushed++;
                m_run  = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sample_en = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic sample(input logic [NDIG-1:0] a, input logic [6:0] s);
        sample_en = 1'b1; an = a; seg = s;
        model_sample(a, s);
        cyc();
        sample_en = 1'b0;
    endtask

    // Issued while the DUT is waiting to hand out a frame; must have no effect.
    task automatic drop_sample(input logic [NDIG-1:0] a, input logic [6:0] s);
        sample_en = 1'b1; an = a; seg = s;
        cyc();
        sample_en = 1'b0;
    endtask

    function automatic logic [NDIG-1:0] sel(input int k);
        return ~(NDIG'(1) << k);
    endfunction

    task automatic scan_digit(input int k, input logic [6:0] s, input int reps);
        for (int r = 0; r < reps; r++) sample(sel(k), s);
    endtask

    task automatic scan_vals(input logic [4*NDIG-1:0] vals, input int lo, input int hi);
        logic [3:0] v;
        for (int k = lo; k <= hi; k++) begin
            v = vals[4*k +: 4];
            scan_digit(k, SEG_TAB[v], 2);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_en = 1'b0;
        model_reset();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic [6:0] pick_pattern();
        int r = $urandom_range(19);
        if (r < 10) return SEG_TAB[r];
        if (r < 12) return 7'h7F;
        if (r < 16) return HEX_TAB[$urandom_range(5)];
        return 7'($urandom);
    endfunction

    task automatic random_frame();
        int guard = 0;
        int k, reps, pick;
        logic [6:0] s;
        m_done = 0;
        while (!m_done && guard < 400) begin
            guard++;
            if ($urandom_range(99) < 12) begin
                pick = $urandom_range(2);
                sample((pick == 0) ? 8'hFF : (pick == 1) ? 8'hFC : 8'h00, 7'($urandom));
            end else begin
                k    = $urandom_range(NDIG - 1);
                s    = pick_pattern();
                reps = $urandom_range(1, 3);
                for (int r = 0; r < reps; r++)
                    if (!m_done) sample(sel(k), s);
            end
        end
        chk("random_frame_completed", 64'(m_done), 64'd1);
        idle(5);
    endtask

    // Monitor: pops on every accepted handout and checks held frames do not move.
    bit     hold_pend = 0;
    frame_t held;
    always @(negedge clk) begin
        frame_t e;
        if (rst) begin
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid",  64'(frame_valid),  64'd1);
                chk("hold_digits", 64'(frame_digits), 64'(held.dig));
                chk("hold_blank",  64'(frame_blank),  64'(held.blank));
                chk("hold_err",    64'(frame_err),    64'(held.err));
            end
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got digits %h, no frame expected", frame_digits);
                end else begin
                    e = exp_q.pop_front();
                    frames_rcv++;
                    chk("frame_digits", 64'(frame_digits), 64'(e.dig));
                    chk("frame_blank",  64'(frame_blank),  64'(e.blank));
                    chk("frame_err",    64'(frame_err),    64'(e.err));
                end
            end
            hold_pend  = frame_valid && !frame_ready;
            held.dig   = frame_digits;
            held.blank = frame_blank;
            held.err   = frame_err;
        end
    end

    initial begin
        do_reset();
        chk("reset_valid",  64'(frame_valid),  64'd0);
        chk("reset_digits", 64'(frame_digits), 64'd0);
        chk("reset_blank",  64'(frame_blank),  64'd0);
        chk("reset_err",    64'(frame_err),    64'd0);

        // Basic frame with latency and single-cycle valid.
        frame_ready = 1'b1;
        scan_vals(32'h76543210, 0, NDIG - 1);
        chk("lat_edge0", 64'(frame_valid), 64'd0);
        cyc();
        chk("lat_edge1", 64'(frame_valid), 64'd0);
        cyc();
        chk("lat_edge2", 64'(frame_valid), 64'd1);
        chk("basic_digits", 64'(frame_digits), 64'h76543210);
        cyc();
        chk("valid_one_cycle", 64'(frame_valid), 64'd0);
        idle(3);

        // Glitch on digit 3.
        scan_vals(32'h76543210, 0, 2);
        sample(sel(3), SEG_TAB[2]);
        scan_digit(3, SEG_TAB[3], 2);
        scan_vals(32'h76543210, 4, NDIG - 1);
        idle(5);

        // Invalid selects interleaved.
        for (int k = 0; k < NDIG; k++) begin
            sample(8'hFF, SEG_TAB[k]);
            sample(sel(k), SEG_TAB[(k + 5) % 10]);
            sample(8'hFC, SEG_TAB[(k + 5) % 10]);
            scan_digit(k, SEG_TAB[(k + 5) % 10], 2);
        end
        idle(5);

        // Backpressure: frame 1 held, frame 2 collected, scans in PEND dropped.
        frame_ready = 1'b0;
        scan_vals(32'h13579246, 0, NDIG - 1);
        idle(4);
        scan_vals(32'h01234567, 0, NDIG - 1);
        idle(4);
        for (int k = 0; k < NDIG; k++) begin
            drop_sample(sel(k), SEG_TAB[8]);
            drop_sample(sel(k), SEG_TAB[8]);
            drop_sample(sel(k), SEG_TAB[8]);
        end
        chk("bp_frame1_held", 64'(frame_digits), 64'h13579246);
        frame_ready = 1'b1;
        cyc();
        chk("bp_frame2_next_edge", 64'(frame_digits), 64'h01234567);
        chk("bp_frame2_valid", 64'(frame_valid), 64'd1);
        idle(5);

        // Blank and hex/undecodable patterns.
        scan_vals(32'h00043210, 0, 4);
        scan_digit(5, 7'b1111111, 2);
        scan_digit(6, 7'b0001000, 2);
        scan_digit(7, SEG_TAB[9], 2);
        idle(5);

        // Reset with a held frame and a partial shadow.
        frame_ready = 1'b0;
        scan_vals(32'h98765432, 0, NDIG - 1);
        idle(4);
        scan_vals(32'h11111111, 0, 3);
        do_reset();
        chk("rst_mid_valid",  64'(frame_valid),  64'd0);
        chk("rst_mid_digits", 64'(frame_digits), 64'd0);
        chk("rst_mid_blank",  64'(frame_blank),  64'd0);
        chk("rst_mid_err",    64'(frame_err),    64'd0);
        frame_ready = 1'b1;
        scan_vals(32'h42424242, 4, NDIG - 1);
        idle(5);
        chk("no_partial_frame", 64'(frame_valid), 64'd0);
        scan_vals(32'h42424242, 0, 3);
        idle(5);

        for (int f = 0; f < 20; f++) random_frame();

        idle(10);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("frames_delivered", 64'(frames_rcv), 64'(frames_pushed - frames_flushed));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
